// File: rtl/spike_rate_decoder_pkg.sv
// Types and default sizes shared by the spike-rate decoder and the network wrapper.
package snn_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } snn_state_t;

  localparam int SNN_N_CH  = 4;
  localparam int SNN_CNT_W = 8;
  localparam int SNN_WIN_W = 8;

  // Keeps select ports at least one bit wide for a single-channel build.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spike_rate_decoder_if.sv
// Control, spike and readout bundle of the spike-rate decoder.
interface spike_rate_decoder_if
  import snn_pkg::*;
#(
  parameter int N_CH  = SNN_N_CH,
  parameter int CNT_W = SNN_CNT_W,
  parameter int WIN_W = SNN_WIN_W
);
  localparam int SEL_W = sel_width(N_CH);

  logic             enable;
  logic [WIN_W-1:0] win_len;
  logic [N_CH-1:0]  spike_in;
  logic [SEL_W-1:0] sel;
  logic [CNT_W-1:0] count_out;
  logic             count_valid;
  logic [SEL_W-1:0] winner;
  logic             any_spike;
  logic             overflow;

  modport master (
    output enable, win_len, spike_in, sel,
    input  count_out, count_valid, winner, any_spike, overflow
  );

  modport slave (
    input  enable, win_len, spike_in, sel,
    output count_out, count_valid, winner, any_spike, overflow
  );

endinterface

// File: rtl/spike_rate_decoder_counter.sv
// One channel: rising-edge detect, saturating window accumulator and sticky saturation flag.
module spike_counter_sat #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_spike,
  input  logic             i_count_en,
  input  logic             i_clear,
  output logic [CNT_W-1:0] o_next_acc,
  output logic             o_next_sat
);
  logic             r_prev;
  logic [CNT_W-1:0] r_acc;
  logic             r_sat;
  logic             w_edge;
  logic             w_full;

  assign w_edge = i_spike & ~r_prev;
  assign w_full = (r_acc == '1);

  // Saturation is flagged when an edge arrives that the full accumulator cannot hold.
  assign o_next_acc = (w_edge && !w_full) ? r_acc + CNT_W'(1) : r_acc;
  assign o_next_sat = r_sat | (w_edge & w_full);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prev <= 1'b0;
      r_acc  <= '0;
      r_sat  <= 1'b0;
    end else begin
      r_prev <= i_spike;
      if (i_clear) begin
        r_acc <= '0;
        r_sat <= 1'b0;
      end else if (i_count_en) begin
        r_acc <= o_next_acc;
        r_sat <= o_next_sat;
      end
    end
  end

endmodule

// File: rtl/spike_rate_decoder.sv
// Windowed spike-rate decoder: per-channel edge counts latched at each window end, plus argmax.
module spike_rate_decoder
  import snn_pkg::*;
#(
  parameter int N_CH  = SNN_N_CH,
  parameter int CNT_W = SNN_CNT_W,
  parameter int WIN_W = SNN_WIN_W
) (
  input logic clk,
  input logic rst_n,
  spike_rate_decoder_if.slave bus
);
  localparam int SEL_W = sel_width(N_CH);

  snn_state_t       r_state;
  logic [WIN_W-1:0] r_win_reg;
  logic [WIN_W-1:0] r_win_cnt;
  logic [CNT_W-1:0] r_result [N_CH];
  logic             r_count_valid;
  logic [SEL_W-1:0] r_winner;
  logic             r_any_spike;
  logic             r_overflow;

  logic [CNT_W-1:0] w_next_acc [N_CH];
  logic [N_CH-1:0]  w_next_sat;
  logic             w_counting;
  logic             w_last;
  logic             w_clear;
  logic [CNT_W-1:0] w_best;
  logic [SEL_W-1:0] w_winner;

  assign w_counting = (r_state == COUNT);
  assign w_last     = w_counting && (r_win_cnt == r_win_reg - WIN_W'(1));
  assign w_clear    = w_counting && (!bus.enable || w_last);

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      spike_counter_sat #(.CNT_W(CNT_W)) u_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_spike    (bus.spike_in[gi]),
        .i_count_en (w_counting),
        .i_clear    (w_clear),
        .o_next_acc (w_next_acc[gi]),
        .o_next_sat (w_next_sat[gi])
      );
    end
  endgenerate

  // Strict compare keeps the lowest index on ties and index 0 when everything is zero.
  always_comb begin
    w_best   = '0;
    w_winner = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (w_next_acc[i] > w_best) begin
        w_best   = w_next_acc[i];
        w_winner = SEL_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_win_reg     <= '0;
      r_win_cnt     <= '0;
      r_count_valid <= 1'b0;
      r_winner      <= '0;
      r_any_spike   <= 1'b0;
      r_overflow    <= 1'b0;
      for (int i = 0; i < N_CH; i++) r_result[i] <= '0;
    end else begin
      r_count_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.enable && bus.win_len != '0) begin
            r_state   <= COUNT;
            r_win_reg <= bus.win_len;
            r_win_cnt <= '0;
          end
        end
        COUNT: begin
          // An abort beats a coinciding window end: results stay as they were.
          if (!bus.enable) begin
            r_state   <= IDLE;
            r_win_cnt <= '0;
          end else if (w_last) begin
            for (int i = 0; i < N_CH; i++) r_result[i] <= w_next_acc[i];
            r_count_valid <= 1'b1;
            r_winner      <= w_winner;
            r_any_spike   <= (w_best != '0);
            r_overflow    <= |w_next_sat;
            r_win_cnt     <= '0;
            if (bus.win_len == '0) r_state <= IDLE;
            else                   r_win_reg <= bus.win_len;
          end else begin
            r_win_cnt <= r_win_cnt + WIN_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.count_out   = r_result[bus.sel];
  assign bus.count_valid = r_count_valid;
  assign bus.winner      = r_winner;
  assign bus.any_spike   = r_any_spike;
  assign bus.overflow    = r_overflow;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Randomised and directed checks of spike_rate_decoder against a window-level edge-count model.
module tb_spike_rate_decoder;
  import snn_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       en_a = 1'b0;
  logic       en_b = 1'b0;
  logic [7:0] win_len = 8'd0;
  logic [3:0] spike = 4'd0;
  logic [1:0] sel = 2'd0;

  spike_rate_decoder_if #(.N_CH(4), .CNT_W(8), .WIN_W(8)) bus_a ();
  spike_rate_decoder_if #(.N_CH(4), .CNT_W(4), .WIN_W(8)) bus_b ();

  assign bus_a.enable = en_a;    assign bus_b.enable = en_b;
  assign bus_a.win_len = win_len; assign bus_b.win_len = win_len;
  assign bus_a.spike_in = spike;  assign bus_b.spike_in = spike;
  assign bus_a.sel = sel;         assign bus_b.sel = sel;

  spike_rate_decoder #(.N_CH(4), .CNT_W(8), .WIN_W(8)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  spike_rate_decoder #(.N_CH(4), .CNT_W(4), .WIN_W(8)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  int tests_run = 0;
  int fails = 0;
  int exp_cnt [4];
  int exp_win;
  bit exp_any, exp_ovf;
  int got [4];
  logic [3:0] last_vec = 4'd0;

  // One clock: drive spike lines, then observe 1 ns after the rising edge.
  task automatic step(input logic [3:0] v);
    spike = v;
    @(posedge clk);
    #1;
    last_vec = v;
  endtask

  task automatic drive_seq(input logic [3:0] seq[$], output int hits, output int last);
    hits = 0;
    last = 0;
    foreach (seq[k]) begin
      step(seq[k]);
      if (bus_a.count_valid === 1'b1) begin
        hits++;
        last = k + 1;
      end
    end
  endtask

  task automatic start(input logic [7:0] w, input logic [3:0] prev);
    win_len = w;
    en_a = 1'b1;
    step(prev);
  endtask

  task automatic stop();
    en_a = 1'b0;
    step(last_vec);
    step(last_vec);
  endtask

  task automatic read_counts();
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      #1;
      got[i] = int'(bus_a.count_out);
    end
  endtask

  // Window-level model: rising edges per line over the window, clipped at maxc.
  function automatic void model(input logic [3:0] prev, input logic [3:0] seq[$], input int maxc);
    int edges [4] = '{default: 0};
    int best;
    logic [3:0] p;
    p = prev;
    foreach (seq[k]) begin
      for (int i = 0; i < 4; i++) if (seq[k][i] && !p[i]) edges[i]++;
      p = seq[k];
    end
    exp_ovf = 1'b0;
    exp_win = 0;
    best = 0;
    for (int i = 0; i < 4; i++) begin
      exp_cnt[i] = (edges[i] > maxc) ? maxc : edges[i];
      if (edges[i] > maxc) exp_ovf = 1'b1;
      if (exp_cnt[i] > best) begin
        best = exp_cnt[i];
        exp_win = i;
      end
    end
    exp_any = (best > 0);
  endfunction

  task automatic test_reset();
    logic [3:0] seq[$];
    int hits, last, nz;
    rst_n = 1'b0; en_a = 1'b1; win_len = 8'd5;
    step(4'b1111); step(4'b0000); step(4'b1111);
    read_counts();
    nz = got[0] | got[1] | got[2] | got[3];
    tests_run++;
    if ({bus_a.count_valid, bus_a.winner, bus_a.any_spike, bus_a.overflow} !== 5'd0 || nz != 0) begin
      fails++;
      $display("FAIL reset_initial got cv=%b win=%0d any=%b ovf=%b cnt_or=%0d want all 0",
               bus_a.count_valid, bus_a.winner, bus_a.any_spike, bus_a.overflow, nz);
    end
    en_a = 1'b0; rst_n = 1'b1; step(4'b0000);
    start(8'd4, 4'b0000);
    seq = '{4'b1111, 4'b0000, 4'b1010, 4'b0000};
    drive_seq(seq, hits, last);
    model(4'b0000, seq, 255);
    tests_run++;
    if (bus_a.winner !== 2'(exp_win) || bus_a.any_spike !== exp_any) begin
      fails++;
      $display("FAIL reset_prewindow got win=%0d any=%b want win=%0d any=%b",
               bus_a.winner, bus_a.any_spike, exp_win, exp_any);
    end
    step(4'b1111); step(4'b0000);
    rst_n = 1'b0;
    step(4'b1111);
    read_counts();
    nz = got[0] | got[1] | got[2] | got[3];
    tests_run++;
    if ({bus_a.count_valid, bus_a.winner, bus_a.any_spike, bus_a.overflow} !== 5'd0 || nz != 0) begin
      fails++;
      $display("FAIL reset_midwindow got cv=%b win=%0d any=%b ovf=%b cnt_or=%0d want all 0",
               bus_a.count_valid, bus_a.winner, bus_a.any_spike, bus_a.overflow, nz);
    end
    en_a = 1'b0; rst_n = 1'b1;
    hits = 0;
    for (int k = 0; k < 20; k++) begin
      step(4'($urandom));
      if (bus_a.count_valid === 1'b1) hits++;
    end
    tests_run++;
    if (hits != 0) begin
      fails++;
      $display("FAIL reset_idle_cv got %0d pulses want 0", hits);
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_basic_rate();
    logic [3:0] seq[$];
    int hits, last;
    start(8'd10, 4'b0000);
    for (int k = 1; k <= 10; k++) seq.push_back((k % 2 == 1) ? 4'b0010 : 4'b0000);
    drive_seq(seq, hits, last);
    model(4'b0000, seq, 255);
    tests_run++;
    if (hits != 1 || last != 10) begin
      fails++;
      $display("FAIL basic_cv_timing got hits=%0d at=%0d want hits=1 at=10", hits, last);
    end
    read_counts();
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (got[i] != exp_cnt[i]) begin
        fails++;
        $display("FAIL basic_count ch%0d got %0d want %0d", i, got[i], exp_cnt[i]);
      end
    end
    tests_run++;
    if (bus_a.winner !== 2'(exp_win) || bus_a.any_spike !== exp_any || bus_a.overflow !== exp_ovf) begin
      fails++;
      $display("FAIL basic_flags got win=%0d any=%b ovf=%b want win=%0d any=%b ovf=%b",
               bus_a.winner, bus_a.any_spike, bus_a.overflow, exp_win, exp_any, exp_ovf);
    end
    step(4'b0000);
    tests_run++;
    if (bus_a.count_valid !== 1'b0) begin
      fails++;
      $display("FAIL basic_cv_pulse got %b want 0", bus_a.count_valid);
    end
    stop();
    $display("[TB] test_basic_rate done");
  endtask

  task automatic test_held_high();
    logic [3:0] seq[$];
    logic [3:0] prev;
    int hits, last;
    for (int v = 0; v < 2; v++) begin
      prev = (v == 1) ? 4'b0100 : 4'b0000;
      seq = {};
      for (int k = 1; k <= 6; k++) seq.push_back((k == 6) ? 4'b0101 : 4'b0100);
      start(8'd6, prev);
      drive_seq(seq, hits, last);
      model(prev, seq, 255);
      read_counts();
      tests_run++;
      if (hits != 1 || got[0] != exp_cnt[0] || got[2] != exp_cnt[2] || bus_a.winner !== 2'(exp_win)) begin
        fails++;
        $display("FAIL held_high v%0d got hits=%0d ch0=%0d ch2=%0d win=%0d want hits=1 ch0=%0d ch2=%0d win=%0d",
                 v, hits, got[0], got[2], bus_a.winner, exp_cnt[0], exp_cnt[2], exp_win);
      end
      stop();
    end
    $display("[TB] test_held_high done");
  endtask

  task automatic test_saturation();
    logic [3:0] seq[$];
    int hits, last, hits_b;
    start(8'd255, 4'b0000);
    for (int k = 1; k <= 255; k++) seq.push_back((k % 2 == 1) ? 4'b1000 : 4'b0000);
    drive_seq(seq, hits, last);
    model(4'b0000, seq, 255);
    read_counts();
    tests_run++;
    if (hits != 1 || last != 255 || got[3] != exp_cnt[3] || bus_a.overflow !== exp_ovf) begin
      fails++;
      $display("FAIL sat_wide got hits=%0d at=%0d ch3=%0d ovf=%b want hits=1 at=255 ch3=%0d ovf=%b",
               hits, last, got[3], bus_a.overflow, exp_cnt[3], exp_ovf);
    end
    stop();
    seq = {};
    for (int k = 1; k <= 40; k++) seq.push_back((k % 2 == 1) ? 4'b1000 : 4'b0000);
    win_len = 8'd40; en_b = 1'b1;
    step(4'b0000);
    hits_b = 0;
    foreach (seq[k]) begin
      step(seq[k]);
      if (bus_b.count_valid === 1'b1) hits_b++;
    end
    model(4'b0000, seq, 15);
    sel = 2'd3;
    #1;
    tests_run++;
    if (hits_b != 1 || bus_b.count_valid !== 1'b1 || int'(bus_b.count_out) != exp_cnt[3] || bus_b.overflow !== exp_ovf) begin
      fails++;
      $display("FAIL sat_narrow got hits=%0d cv=%b ch3=%0d ovf=%b want hits=1 cv=1 ch3=%0d ovf=%b",
               hits_b, bus_b.count_valid, bus_b.count_out, bus_b.overflow, exp_cnt[3], exp_ovf);
    end
    en_b = 1'b0;
    step(4'b0000); step(4'b0000);
    $display("[TB] test_saturation done");
  endtask

  task automatic test_tie_abort();
    logic [3:0] seq[$];
    int hits, last, saved [4];
    int saved_win;
    start(8'd8, 4'b0000);
    seq = '{4'b0001, 4'b0100, 4'b0001, 4'b0100, 4'b0001, 4'b0100, 4'b0000, 4'b0000};
    drive_seq(seq, hits, last);
    model(4'b0000, seq, 255);
    read_counts();
    tests_run++;
    if (bus_a.winner !== 2'(exp_win) || got[0] != exp_cnt[0] || got[2] != exp_cnt[2]) begin
      fails++;
      $display("FAIL tie_winner got win=%0d ch0=%0d ch2=%0d want win=%0d ch0=%0d ch2=%0d",
               bus_a.winner, got[0], got[2], exp_win, exp_cnt[0], exp_cnt[2]);
    end
    saved = exp_cnt;
    saved_win = exp_win;
    hits = 0;
    for (int k = 1; k <= 11; k++) begin
      if (k == 8) en_a = 1'b0;
      step(4'($urandom));
      if (bus_a.count_valid === 1'b1) hits++;
    end
    read_counts();
    tests_run++;
    if (hits != 0 || got != saved || bus_a.winner !== 2'(saved_win)) begin
      fails++;
      $display("FAIL abort_hold got hits=%0d ch0=%0d ch2=%0d win=%0d want hits=0 ch0=%0d ch2=%0d win=%0d",
               hits, got[0], got[2], bus_a.winner, saved[0], saved[2], saved_win);
    end
    seq = {};
    for (int k = 0; k < 3; k++) seq.push_back(4'($urandom));
    model(last_vec, seq, 255);
    start(8'd3, last_vec);
    drive_seq(seq, hits, last);
    read_counts();
    tests_run++;
    if (hits != 1 || got != exp_cnt) begin
      fails++;
      $display("FAIL abort_restart got hits=%0d cnt=%0d/%0d/%0d/%0d want hits=1 cnt=%0d/%0d/%0d/%0d",
               hits, got[0], got[1], got[2], got[3], exp_cnt[0], exp_cnt[1], exp_cnt[2], exp_cnt[3]);
    end
    stop();
    $display("[TB] test_tie_abort done");
  endtask

  task automatic test_back_to_back();
    logic [3:0] hist [19];
    logic [3:0] seq[$];
    int starts [4] = '{1, 5, 9, 13};
    int ends   [4] = '{4, 8, 12, 18};
    int wi, sum_got, sum_edges;
    bit want_cv;
    wi = 0; sum_got = 0; sum_edges = 0;
    win_len = 8'd4; en_a = 1'b1;
    for (int k = 0; k < 19; k++) begin
      if (k == 10) win_len = 8'd6;
      hist[k] = 4'($urandom);
      step(hist[k]);
      want_cv = (wi < 4) && (k == ends[wi]);
      tests_run++;
      if (bus_a.count_valid !== want_cv) begin
        fails++;
        $display("FAIL b2b_cv cycle %0d got %b want %b", k + 1, bus_a.count_valid, want_cv);
      end
      if (want_cv) begin
        seq = {};
        for (int j = starts[wi]; j <= ends[wi]; j++) seq.push_back(hist[j]);
        model(hist[starts[wi] - 1], seq, 255);
        read_counts();
        tests_run++;
        if (got != exp_cnt || bus_a.winner !== 2'(exp_win)) begin
          fails++;
          $display("FAIL b2b_window %0d got %0d/%0d/%0d/%0d win=%0d want %0d/%0d/%0d/%0d win=%0d", wi,
                   got[0], got[1], got[2], got[3], bus_a.winner,
                   exp_cnt[0], exp_cnt[1], exp_cnt[2], exp_cnt[3], exp_win);
        end
        sum_got += got[0] + got[1] + got[2] + got[3];
        wi++;
      end
    end
    for (int k = 1; k < 19; k++)
      for (int i = 0; i < 4; i++)
        if (hist[k][i] && !hist[k-1][i]) sum_edges++;
    tests_run++;
    if (sum_got != sum_edges) begin
      fails++;
      $display("FAIL b2b_total got %0d want %0d", sum_got, sum_edges);
    end
    stop();
    $display("[TB] test_back_to_back done");
  endtask

  task automatic test_random();
    logic [3:0] seq[$];
    logic [3:0] prev;
    int hits, last, w;
    for (int t = 0; t < 6; t++) begin
      w = (t == 0) ? 1 : int'($urandom_range(2, 16));
      prev = 4'($urandom);
      seq = {};
      for (int k = 0; k < w; k++) seq.push_back(4'($urandom));
      model(prev, seq, 255);
      start(8'(w), prev);
      drive_seq(seq, hits, last);
      read_counts();
      tests_run++;
      if (hits != 1 || last != w || got != exp_cnt || bus_a.winner !== 2'(exp_win) ||
          bus_a.any_spike !== exp_any || bus_a.overflow !== exp_ovf) begin
        fails++;
        $display("FAIL random t%0d w=%0d got hits=%0d at=%0d cnt=%0d/%0d/%0d/%0d win=%0d any=%b want cnt=%0d/%0d/%0d/%0d win=%0d any=%b",
                 t, w, hits, last, got[0], got[1], got[2], got[3], bus_a.winner, bus_a.any_spike,
                 exp_cnt[0], exp_cnt[1], exp_cnt[2], exp_cnt[3], exp_win, exp_any);
      end
      stop();
    end
    $display("[TB] test_random done");
  endtask

  initial begin
    test_reset();
    test_basic_rate();
    test_held_high();
    test_saturation();
    test_tie_abort();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
